// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg : shared HD44780 state encoding, 50 MHz timing defaults and field codes
// Rev 1.0
// ============================================================================
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_E_HI  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4,
      ST_RESP  = 3'd5
   } lcd_state_t;

   localparam int LCD_SETUP_CYC  = 3;
   localparam int LCD_E_HIGH_CYC = 25;
   localparam int LCD_HOLD_CYC   = 2;
   localparam int LCD_GAP_CYC    = 25;
   localparam int LCD_MAX_POLLS  = 4096;

   localparam int   LCD_BF_BIT  = 7;
   localparam logic LCD_RS_CMD  = 1'b0;
   localparam logic LCD_RS_DATA = 1'b1;

   function automatic int lcd_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_phase_timer.sv
`default_nettype none
// ============================================================================
// lcd_phase_timer : loadable down-counter; done is high while the count is zero
// Rev 1.0
// ============================================================================
module lcd_phase_timer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst)
         r_count <= '0;
      else if (load)
         r_count <= load_val;
      else if (r_count != '0)
         r_count <= r_count - 1'b1;
   end

   // A phase of N cycles is loaded with N-1 so done marks its final cycle.
   assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_reader.sv
`default_nettype none
// ============================================================================
// lcd_reader : HD44780 read-cycle sequencer with optional busy-flag polling
// Rev 1.0
// ============================================================================
module lcd_reader
   import lcd_pkg::*;
#(
   parameter int SETUP_CYC  = LCD_SETUP_CYC,
   parameter int E_HIGH_CYC = LCD_E_HIGH_CYC,
   parameter int HOLD_CYC   = LCD_HOLD_CYC,
   parameter int GAP_CYC    = LCD_GAP_CYC,
   parameter int MAX_POLLS  = LCD_MAX_POLLS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic       req_poll,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_timeout,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_E,
   input  logic [7:0] LCD_DataBus_in,
   output logic       owns_bus
);

   localparam int MAX_PH = lcd_max(lcd_max(SETUP_CYC, E_HIGH_CYC), lcd_max(HOLD_CYC, GAP_CYC));
   localparam int CW     = $clog2(MAX_PH + 1);
   localparam int PW     = $clog2(MAX_POLLS + 1);

   lcd_state_t      r_state;
   logic            r_poll;
   logic [PW-1:0]   r_poll_cnt;

   logic            w_accept;
   logic            w_more;
   logic            w_done;
   logic            w_load;
   logic [CW-1:0]   w_load_val;

   assign w_accept = req_valid & req_ready;
   assign w_more   = r_poll & rsp_data[LCD_BF_BIT] & (r_poll_cnt < PW'(MAX_POLLS));

   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         ST_IDLE:  if (w_accept) begin w_load = 1'b1; w_load_val = CW'(SETUP_CYC - 1);  end
         ST_SETUP: if (w_done)   begin w_load = 1'b1; w_load_val = CW'(E_HIGH_CYC - 1); end
         ST_E_HI:  if (w_done)   begin w_load = 1'b1; w_load_val = CW'(HOLD_CYC - 1);   end
         ST_HOLD:  if (w_done && w_more) begin w_load = 1'b1; w_load_val = CW'(GAP_CYC - 1); end
         ST_GAP:   if (w_done)   begin w_load = 1'b1; w_load_val = CW'(SETUP_CYC - 1);  end
         default: ;
      endcase
   end

   lcd_phase_timer #(.WIDTH(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val (w_load_val),
      .done     (w_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_poll      <= 1'b0;
         r_poll_cnt  <= '0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
         LCD_RS      <= 1'b0;
         LCD_RW      <= 1'b0;
         LCD_E       <= 1'b0;
         owns_bus    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               req_ready <= 1'b1;
               if (w_accept) begin
                  // Polling only makes sense on the busy-flag/address register.
                  r_poll      <= req_poll & (req_rs != LCD_RS_DATA);
                  r_poll_cnt  <= '0;
                  rsp_timeout <= 1'b0;
                  req_ready   <= 1'b0;
                  LCD_RS      <= req_rs;
                  LCD_RW      <= 1'b1;
                  LCD_E       <= 1'b0;
                  owns_bus    <= 1'b1;
                  r_state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_done) begin
                  LCD_E   <= 1'b1;
                  r_state <= ST_E_HI;
               end
            end
            ST_E_HI: begin
               if (w_done) begin
                  LCD_E    <= 1'b0;
                  rsp_data <= LCD_DataBus_in;
                  if (r_poll_cnt != PW'(MAX_POLLS))
                     r_poll_cnt <= r_poll_cnt + 1'b1;
                  r_state  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (w_done) begin
                  if (w_more) begin
                     r_state <= ST_GAP;
                  end else begin
                     rsp_timeout <= r_poll & rsp_data[LCD_BF_BIT];
                     rsp_valid   <= 1'b1;
                     owns_bus    <= 1'b0;
                     LCD_RW      <= 1'b0;
                     LCD_RS      <= LCD_RS_CMD;
                     r_state     <= ST_RESP;
                  end
               end
            end
            ST_GAP: begin
               if (w_done)
                  r_state <= ST_SETUP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/lcd_reader.md
# lcd_reader

Read-side companion to the team's HD44780 character-LCD write path. The block performs HD44780 read cycles (RW=1) to fetch the busy-flag/address-counter byte (RS=0) or a DDRAM/CGRAM data byte (RS=1), and can optionally poll the busy flag until it clears. It sits beside the LCD write logic on the same 8-bit LCD bus; `owns_bus` tells the top-level mux which side drives the LCD pins.

## Interface
Parameters:
- `SETUP_CYC`, default 3: cycles with RS/RW stable and E low before E rises. Covers tAS ≥ 60 ns at 50 MHz.
- `E_HIGH_CYC`, default 25: E high width in cycles. Covers PWEH ≥ 450 ns.
- `HOLD_CYC`, default 2: cycles with RS/RW held after E falls.
- `GAP_CYC`, default 25: E-low gap between consecutive poll reads. Keeps tcyc ≥ 1000 ns.
- `MAX_POLLS`, default 4096: maximum reads in one poll request, ≥ 1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: read request.
- `req_ready` out 1: high only in IDLE.
- `req_rs` in 1: 0 = busy/address read, 1 = data read.
- `req_poll` in 1: repeat the read while bit 7 is 1. Honoured only when `req_rs`=0.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out 8: last sampled byte.
- `rsp_timeout` out 1: poll exhausted with busy flag still set.
- `LCD_RS`, `LCD_RW`, `LCD_E` out 1: LCD control pins, all registered.
- `LCD_DataBus_in` in 8: LCD data bus, input side. This block never drives the bus.
- `owns_bus` out 1: high from accept until the response is issued.

## Operation
- Reset values: `req_ready`=0 during reset and 1 in IDLE afterwards. All of these are 0: `rsp_valid`, `rsp_data`, `rsp_timeout`, `LCD_RS`, `LCD_RW`, `LCD_E`, `owns_bus`. The poll count is 0.
- States: IDLE → SETUP → E_HI → HOLD → (GAP → SETUP …) → RESP → IDLE.
- IDLE
  - Accept when `req_valid` and `req_ready` are both high.
  - Latch `rs = req_rs` and `poll = req_poll & ~req_rs`.
  - Clear the poll count and go to SETUP.
- SETUP: `LCD_RS`=rs, `LCD_RW`=1, `LCD_E`=0, `owns_bus`=1. Lasts SETUP_CYC cycles.
- E_HI
  - `LCD_E`=1 for E_HIGH_CYC cycles.
  - `LCD_DataBus_in` is sampled into `rsp_data` on the clock edge that ends the last E-high cycle.
  - The poll count increments at that same edge.
- HOLD: E=0 with RS/RW held, for HOLD_CYC cycles. At HOLD end:
  - poll=1, `rsp_data[7]`=1 and count < MAX_POLLS → GAP.
  - poll=1, `rsp_data[7]`=1 and count = MAX_POLLS → RESP with `rsp_timeout`=1.
  - Otherwise → RESP with `rsp_timeout`=0.
- GAP: E=0, RS/RW held, `owns_bus`=1. Lasts GAP_CYC cycles, then back to SETUP.
- RESP
  - `rsp_valid`=1 and `owns_bus`=0.
  - `LCD_RW` returns to 0 and `LCD_RS` to 0.
  - `rsp_data` and `rsp_timeout` are held stable until `rsp_valid` and `rsp_ready` are both high, then IDLE.
- While not in IDLE, `req_valid` is ignored: no queuing, no corruption of the op in flight.
- Counters
  - One phase down-counter of width $clog2(max(SETUP_CYC, E_HIGH_CYC, HOLD_CYC, GAP_CYC)+1).
  - Poll counter of width $clog2(MAX_POLLS+1). It saturates and never wraps.

## Timing
- Accept edge = cycle 0.
- SETUP: cycles 1..SETUP_CYC.
- E high: cycles SETUP_CYC+1 .. SETUP_CYC+E_HIGH_CYC.
- `rsp_valid` rises in cycle SETUP_CYC+E_HIGH_CYC+HOLD_CYC+1. With defaults this is cycle 31.
- Each additional poll read adds GAP_CYC+SETUP_CYC+E_HIGH_CYC+HOLD_CYC cycles. With defaults that is 55.
- If `rsp_ready` is high in the first RESP cycle, `req_ready` is high on the next cycle: minimum 1 idle cycle between ops.
- Reset mid-operation, including during E_HI:
  - On the next edge: `LCD_E`=0, `LCD_RW`=0, `owns_bus`=0, `rsp_valid`=0, state IDLE.
  - No response is issued.

## Structure
- Shared package `lcd_pkg` holds:
  - the state enum;
  - default timing constants for 50 MHz;
  - `LCD_BF_BIT` = 7;
  - RS encodings `LCD_RS_CMD` = 0 and `LCD_RS_DATA` = 1.
  The write path reuses the timing constants.
- Sub-module `lcd_phase_timer`: loadable down-counter with a `done` pulse. It is shared by all phases and reusable by the write-side sequencer.

## Test plan
- Data read:
  - Stimulus: `req_rs`=1, bus = 0x48.
  - Required: `rsp_data`=0x48 and `rsp_timeout`=0 at cycle 31.
  - Required: E high for exactly 25 cycles; RW=1 from cycle 1 through HOLD end.
- Busy poll:
  - Stimulus: `req_rs`=0, `req_poll`=1; bus = 0x85 for the first 2 reads, then 0x05.
  - Required: 3 E pulses, `rsp_data`=0x05, `rsp_timeout`=0, `rsp_valid` at cycle 31+2×55=141.
- Timeout:
  - Stimulus: MAX_POLLS=4, bus held at 0x80.
  - Required: exactly 4 E pulses, `rsp_timeout`=1, `rsp_data`=0x80.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 10 cycles after `rsp_valid`.
  - Required: `rsp_data`/`rsp_valid` stable; `req_ready`=0; a second `req_valid` is ignored. Then `rsp_ready`=1 gives `req_ready`=1 on the next cycle.
- Reset mid E_HI:
  - Stimulus: assert `rst` 1 cycle at cycle 10.
  - Required: `LCD_E`/`LCD_RW`/`owns_bus`=0 on the next edge; no `rsp_valid`; a fresh request then completes normally.
- `req_poll`=1 with `req_rs`=1:
  - Stimulus: bus = 0xFF.
  - Required: single read only, `rsp_data`=0xFF, `rsp_timeout`=0.
